// File: rtl/display_pkg.sv
// Shared types and nibble helpers for the 8-digit scanned 7-segment display.
package display_pkg;
  localparam int NUM_DIGITS_C = 8;
  localparam int DIGIT_IDX_W  = 3;

  typedef logic [3:0]             nibble_t;
  typedef logic [DIGIT_IDX_W-1:0] digit_sel_t;

  function automatic nibble_t nibble_of(input logic [31:0] word, input digit_sel_t idx);
    logic [31:0] w_sh;
    w_sh = word >> {idx, 2'b00};
    return w_sh[3:0];
  endfunction

  // Digit idx is a leading zero when it and every digit above it are zero; digit 0 never is.
  function automatic logic lz_blank(input logic [31:0] word, input digit_sel_t idx);
    logic [31:0] w_sh;
    w_sh = word >> {idx, 2'b00};
    return (idx != '0) && (w_sh == '0);
  endfunction
endpackage

// File: rtl/display_scan_if.sv
// Load request and per-digit scan outputs between the value source, scanner and hex decoder.
interface display_scan_if import display_pkg::*; #(
  parameter int NUM_DIGITS = NUM_DIGITS_C
) ();
  logic [31:0]           data_in;
  logic                  load;
  logic                  load_pending;
  nibble_t               digit_nibble;
  logic                  digit_blank;
  logic [NUM_DIGITS-1:0] anode_n;
  digit_sel_t            digit_idx;
  logic                  frame_start;

  modport master (
    output data_in, load,
    input  load_pending, digit_nibble, digit_blank, anode_n, digit_idx, frame_start
  );

  modport slave (
    input  data_in, load,
    output load_pending, digit_nibble, digit_blank, anode_n, digit_idx, frame_start
  );
endinterface

// File: rtl/scan_tick_gen.sv
// Free-running prescaler: one-cycle tick every PRESCALE clocks, shared by scanned peripherals.
module scan_tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("scan_tick_gen: PRESCALE must be >= 2");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = (r_cnt == CNT_LAST);
  assign tick   = w_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end
endmodule

// File: rtl/display_scan.sv
// Digit scanner: frame-stable shadow of a 32-bit value, one nibble per slot, active-low anodes with dead time.
module display_scan import display_pkg::*; #(
  parameter int NUM_DIGITS = NUM_DIGITS_C,
  parameter int PRESCALE   = 50000,
  parameter int BLANK_LZ   = 1
) (
  input logic           clk,
  input logic           rst_n,
  display_scan_if.slave bus
);
  localparam digit_sel_t IDX_LAST = digit_sel_t'(NUM_DIGITS - 1);
  localparam digit_sel_t IDX_ONE  = digit_sel_t'(1);
  localparam logic [NUM_DIGITS-1:0] ANODE_BIT0 = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  if (NUM_DIGITS != NUM_DIGITS_C) begin : g_bad_digits
    $error("display_scan: NUM_DIGITS must be 8 for 32-bit data");
  end

  logic                  w_tick;
  logic                  w_wrap;
  digit_sel_t            w_idx_step;
  logic [31:0]           w_shadow_next;

  digit_sel_t            r_idx;
  logic [31:0]           r_staging;
  logic [31:0]           r_shadow;
  logic                  r_load_pending;
  logic [NUM_DIGITS-1:0] r_anode_n;
  nibble_t               r_digit_nibble;
  logic                  r_digit_blank;
  logic                  r_frame_start;

  scan_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign w_wrap     = w_tick && (r_idx == IDX_LAST);
  assign w_idx_step = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_ONE;

  // A load landing on the wrap cycle bypasses staging so it is not held a whole extra frame.
  always_comb begin
    w_shadow_next = r_shadow;
    if (w_wrap) begin
      if (bus.load) begin
        w_shadow_next = bus.data_in;
      end else if (r_load_pending) begin
        w_shadow_next = r_staging;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx          <= '0;
      r_staging      <= '0;
      r_shadow       <= '0;
      r_load_pending <= 1'b0;
    end else begin
      if (bus.load) begin
        r_staging <= bus.data_in;
      end
      r_shadow <= w_shadow_next;
      if (w_wrap) begin
        r_load_pending <= 1'b0;
      end else if (bus.load) begin
        r_load_pending <= 1'b1;
      end
      if (w_tick) begin
        r_idx <= w_idx_step;
      end
    end
  end

  // Slot change: all anodes off for one cycle while the decoder settles on the new nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_anode_n      <= '1;
      r_digit_nibble <= '0;
      r_digit_blank  <= 1'b1;
      r_frame_start  <= 1'b0;
    end else if (w_tick) begin
      r_anode_n      <= '1;
      r_digit_nibble <= nibble_of(w_shadow_next, w_idx_step);
      r_digit_blank  <= 1'b1;
      r_frame_start  <= (w_idx_step == '0);
    end else begin
      r_anode_n      <= ~(ANODE_BIT0 << r_idx);
      r_digit_nibble <= nibble_of(r_shadow, r_idx);
      r_digit_blank  <= (BLANK_LZ != 0) && lz_blank(r_shadow, r_idx);
      r_frame_start  <= 1'b0;
    end
  end

  assign bus.load_pending = r_load_pending;
  assign bus.digit_nibble = r_digit_nibble;
  assign bus.digit_blank  = r_digit_blank;
  assign bus.anode_n      = r_anode_n;
  assign bus.digit_idx    = r_idx;
  assign bus.frame_start  = r_frame_start;
endmodule

// File: tb/tb_display_scan.sv
// Directed bench: two scanners (leading-zero blanking on/off) fed identical loads, checked slot by slot.
module tb_display_scan;
  import display_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  display_scan_if #(.NUM_DIGITS(8)) bus  ();
  display_scan_if #(.NUM_DIGITS(8)) bus2 ();

  display_scan #(.NUM_DIGITS(8), .PRESCALE(4), .BLANK_LZ(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  display_scan #(.NUM_DIGITS(8), .PRESCALE(4), .BLANK_LZ(0)) dut_nolz (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_load(input logic ld, input logic [31:0] v);
    bus.load     = ld;
    bus2.load    = ld;
    bus.data_in  = v;
    bus2.data_in = v;
  endtask

  task automatic wait_frame_start();
    int n;
    n = 0;
    while (bus.frame_start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk_eq("frame_start_seen", bus.frame_start, 1'b1);
  endtask

  // Entered in the dead cycle of digit 0; returns in the dead cycle of the next frame's digit 0.
  // Loads are applied in the last lit cycle of the named digit (digit 7 = the wrap cycle).
  task automatic check_frame(input logic [31:0] w, input logic [7:0] bmask,
                             input int ld_a, input logic [31:0] va,
                             input int ld_b, input logic [31:0] vb);
    logic       exp_pend;
    logic [3:0] nib;
    logic [7:0] an;
    exp_pend = 1'b0;
    for (int i = 0; i < 8; i++) begin
      nib = w[4*i +: 4];
      an  = ~(8'h01 << i);
      chk_eq("dead_anode", bus.anode_n, 8'hFF);
      chk_eq("dead_blank", bus.digit_blank, 1'b1);
      chk_eq("dead_idx", bus.digit_idx, i);
      chk_eq("dead_nibble", bus.digit_nibble, nib);
      chk_eq("dead_frame_start", bus.frame_start, (i == 0));
      chk_eq("dead_pending", bus.load_pending, exp_pend);
      chk_eq("nolz_dead_anode", bus2.anode_n, 8'hFF);
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        chk_eq("lit_anode", bus.anode_n, an);
        chk_eq("lit_idx", bus.digit_idx, i);
        chk_eq("lit_nibble", bus.digit_nibble, nib);
        chk_eq("lit_blank", bus.digit_blank, bmask[i]);
        chk_eq("lit_frame_start", bus.frame_start, 1'b0);
        chk_eq("lit_pending", bus.load_pending, exp_pend);
        chk_eq("nolz_blank", bus2.digit_blank, 1'b0);
        chk_eq("nolz_nibble", bus2.digit_nibble, nib);
        if (k == 3 && (i == ld_a || i == ld_b)) begin
          set_load(1'b1, (i == ld_a) ? va : vb);
        end
      end
      @(negedge clk);
      if (bus.load) begin
        if (i != 7) exp_pend = 1'b1;
        set_load(1'b0, 32'h0);
      end
    end
    chk_eq("frame_period", bus.frame_start, 1'b1);
    chk_eq("pending_after_wrap", bus.load_pending, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    set_load(1'b0, 32'h0);

    repeat (3) @(negedge clk);
    chk_eq("rst_anode", bus.anode_n, 8'hFF);
    chk_eq("rst_blank", bus.digit_blank, 1'b1);
    chk_eq("rst_idx", bus.digit_idx, 0);
    chk_eq("rst_nibble", bus.digit_nibble, 0);
    chk_eq("rst_frame_start", bus.frame_start, 1'b0);
    chk_eq("rst_pending", bus.load_pending, 1'b0);
    rst_n = 1'b1;

    @(negedge clk);
    chk_eq("first_anode", bus.anode_n, 8'hFE);
    chk_eq("first_blank", bus.digit_blank, 1'b0);
    wait_frame_start();

    check_frame(32'h0000_0000, 8'hFE, 3, 32'h1234_ABCD, -1, 32'h0);
    check_frame(32'h1234_ABCD, 8'h00, 1, 32'h0000_0F00, -1, 32'h0);
    check_frame(32'h0000_0F00, 8'hF8, 2, 32'h1111_1111, 5, 32'h2222_2222);
    check_frame(32'h2222_2222, 8'h00, 7, 32'hCAFE_F00D, -1, 32'h0);
    check_frame(32'hCAFE_F00D, 8'h00, -1, 32'h0, -1, 32'h0);

    // Pending load, then an asynchronous reset pulse part-way through digit 5.
    set_load(1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    set_load(1'b0, 32'h0);
    chk_eq("pre_rst_pending", bus.load_pending, 1'b1);
    for (int n = 0; n < 40 && bus.digit_idx != 3'd5; n++) @(negedge clk);
    chk_eq("pre_rst_idx", bus.digit_idx, 5);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("async_rst_anode", bus.anode_n, 8'hFF);
    chk_eq("async_rst_blank", bus.digit_blank, 1'b1);
    chk_eq("async_rst_idx", bus.digit_idx, 0);
    chk_eq("async_rst_nibble", bus.digit_nibble, 0);
    chk_eq("async_rst_frame_start", bus.frame_start, 1'b0);
    chk_eq("async_rst_pending", bus.load_pending, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame_start();
    check_frame(32'h0000_0000, 8'hFE, -1, 32'h0, -1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
